// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch stage.
//   FETCH_PC_W / FETCH_INS_W : default PC and instruction widths
//   NOP_INSTR                : instruction word placed in IF/ID when it holds no instruction
//   fetch_state_t            : fetch sequencer states
//   fetch_pkt_t              : {pc, instr} pair carried by the skid buffer and IF/ID
package fetch_pkg;

  localparam int FETCH_PC_W  = 9;
  localparam int FETCH_INS_W = 32;

  localparam logic [FETCH_INS_W-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic {FS_BOOT, FS_RUN} fetch_state_t;

  typedef struct packed {
    logic [FETCH_PC_W-1:0]  pc;
    logic [FETCH_INS_W-1:0] instr;
  } fetch_pkt_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry holding register for a fetched instruction that arrives while
// the pipeline is stalled.
//   clk, reset : clock, synchronous active-high reset
//   flush_i    : discard the held entry (highest priority after reset)
//   load_i     : capture data_i
//   drain_i    : entry consumed this cycle
//   data_i     : packet to capture
//   valid_o    : an entry is held
//   data_o     : held packet
module fetch_skid_buf
  import fetch_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       flush_i,
  input  logic       load_i,
  input  logic       drain_i,
  input  fetch_pkt_t data_i,
  output logic       valid_o,
  output fetch_pkt_t data_o
);

  logic       valid_q;
  fetch_pkt_t data_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else if (flush_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      data_q  <= data_i;
    end else if (drain_i) begin
      valid_q <= 1'b0;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: owns the PC, issues instruction-memory reads, fills IF/ID.
//   clk, reset      : clock, synchronous active-high reset
//   pc_sel, br_pc   : redirect from the branch unit (target low 2 bits forced to 0)
//   stall           : hazard stall, holds IF/ID and blocks new requests
//   imem_req/addr   : read request (addr = pc_q); accepted when imem_req && imem_gnt
//   imem_gnt        : memory accepts the request
//   imem_rvalid/data: read response, exactly one cycle after acceptance
//   ifid_valid/pc/instr : IF/ID register (instr = NOP when not valid)
//   protocol_err    : sticky, response seen with nothing outstanding
//
// Handshake: a request transfers on a rising edge where imem_req && imem_gnt;
// imem_req only depends on state and on stall/pc_sel, never on imem_gnt, and
// the response for a transfer is imem_rvalid in the following cycle.
module fetch_stage
  import fetch_pkg::*;
#(
  parameter int              PC_W     = FETCH_PC_W,
  parameter int              INS_W    = FETCH_INS_W,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             pc_sel,
  input  logic [31:0]      br_pc,
  input  logic             stall,
  output logic             imem_req,
  output logic [PC_W-1:0]  imem_addr,
  input  logic             imem_gnt,
  input  logic             imem_rvalid,
  input  logic [INS_W-1:0] imem_rdata,
  output logic             ifid_valid,
  output logic [PC_W-1:0]  ifid_pc,
  output logic [INS_W-1:0] ifid_instr,
  output logic             protocol_err
);

  fetch_state_t     state_q;
  logic [PC_W-1:0]  pc_q, pc_d;
  logic [PC_W-1:0]  req_pc_q;
  logic             outstanding_q, outstanding_d;
  logic             kill_q, kill_d;
  logic             err_q;
  logic             ifid_valid_q;
  logic [PC_W-1:0]  ifid_pc_q;
  logic [INS_W-1:0] ifid_instr_q;

  logic             hs, rsp, deliver;
  logic [PC_W-1:0]  br_target;
  logic             buf_valid, buf_load, buf_drain;
  fetch_pkt_t       buf_data, rsp_pkt;
  logic             br_pc_unused;

  assign br_pc_unused = ^{br_pc[31:PC_W], br_pc[1:0]};
  assign br_target    = {br_pc[PC_W-1:2], 2'b00};

  assign imem_req  = (state_q == FS_RUN) && !buf_valid && !stall && !pc_sel;
  assign imem_addr = pc_q;
  assign hs        = imem_req && imem_gnt;

  // During FS_BOOT any response belongs to a request accepted before reset,
  // so it is ignored rather than flagged.
  assign rsp     = imem_rvalid && (state_q == FS_RUN);
  assign deliver = rsp && outstanding_q && !kill_q;

  assign rsp_pkt.pc    = req_pc_q;
  assign rsp_pkt.instr = imem_rdata;

  always_comb begin
    pc_d          = pc_q;
    outstanding_d = outstanding_q;
    kill_d        = kill_q;
    if (imem_rvalid) begin
      outstanding_d = 1'b0;
      kill_d        = 1'b0;
    end
    if (hs) begin
      outstanding_d = 1'b1;
      pc_d          = pc_q + PC_W'(4);
    end
    // A read still in flight after this cycle belongs to the wrong path.
    if (pc_sel) begin
      pc_d   = br_target;
      kill_d = outstanding_d;
    end
  end

  assign buf_load  = !pc_sel && stall && deliver;
  assign buf_drain = !pc_sel && !stall && buf_valid;

  fetch_skid_buf u_skid (
    .clk     (clk),
    .reset   (reset),
    .flush_i (pc_sel),
    .load_i  (buf_load),
    .drain_i (buf_drain),
    .data_i  (rsp_pkt),
    .valid_o (buf_valid),
    .data_o  (buf_data)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FS_BOOT;
      pc_q          <= RESET_PC;
      req_pc_q      <= '0;
      outstanding_q <= 1'b0;
      kill_q        <= 1'b0;
      err_q         <= 1'b0;
      ifid_valid_q  <= 1'b0;
      ifid_pc_q     <= '0;
      ifid_instr_q  <= NOP_INSTR;
    end else begin
      case (state_q)
        FS_BOOT: state_q <= FS_RUN;
        default: state_q <= FS_RUN;
      endcase
      pc_q          <= pc_d;
      outstanding_q <= outstanding_d;
      kill_q        <= kill_d;
      if (hs) req_pc_q <= pc_q;
      if (rsp && !outstanding_q) err_q <= 1'b1;

      if (pc_sel) begin
        ifid_valid_q <= 1'b0;
        ifid_instr_q <= NOP_INSTR;
      end else if (stall) begin
        // IF/ID holds; a delivered response is parked in the skid buffer.
      end else if (buf_valid) begin
        ifid_valid_q <= 1'b1;
        ifid_pc_q    <= buf_data.pc;
        ifid_instr_q <= buf_data.instr;
      end else if (deliver) begin
        ifid_valid_q <= 1'b1;
        ifid_pc_q    <= req_pc_q;
        ifid_instr_q <= imem_rdata;
      end else begin
        ifid_valid_q <= 1'b0;
        ifid_instr_q <= NOP_INSTR;
      end
    end
  end

  // No request is issued while the buffer is full, so a delivery can never
  // collide with a held entry.
  assert property (@(posedge clk) disable iff (reset) !(deliver && buf_valid));

  assign ifid_valid   = ifid_valid_q;
  assign ifid_pc      = ifid_pc_q;
  assign ifid_instr   = ifid_instr_q;
  assign protocol_err = err_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage with a behavioural fetch model and an
// instruction memory that answers with instr = address one cycle after accept.
module tb_fetch_stage;
  import fetch_pkg::*;

  localparam int PKT_W = FETCH_PC_W + FETCH_INS_W;

  // clock / reset
  logic        clk = 1'b0;
  logic        reset;
  always #5 clk = ~clk;

  logic        pc_sel, stall, imem_gnt, imem_rvalid;
  logic [31:0] br_pc, imem_rdata;
  logic        imem_req, ifid_valid, protocol_err;
  logic [8:0]  imem_addr, ifid_pc;
  logic [31:0] ifid_instr;

  fetch_stage dut (
    .clk          (clk),
    .reset        (reset),
    .pc_sel       (pc_sel),
    .br_pc        (br_pc),
    .stall        (stall),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_gnt     (imem_gnt),
    .imem_rvalid  (imem_rvalid),
    .imem_rdata   (imem_rdata),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr),
    .protocol_err (protocol_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // behavioural model: fetch pointer, the single read in flight, parked
  // instructions (scoreboard queue) and the IF/ID contents
  bit          m_known = 0;
  bit          m_run   = 0;
  bit          m_infl  = 0;
  bit          m_dead  = 0;
  bit          m_err   = 0;
  bit          m_v     = 0;
  logic [8:0]  m_pc    = '0;
  logic [8:0]  m_infl_addr = '0;
  logic [8:0]  m_ifpc  = '0;
  logic [31:0] m_ifins = NOP_INSTR;
  logic [PKT_W-1:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s (cycle %0d): got %h, expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic chk_ifid(input string name, input logic v, input logic [8:0] pc,
                          input logic [31:0] ins);
    chk({name, ".valid"}, 32'(ifid_valid), 32'(v));
    chk({name, ".pc"}, 32'(ifid_pc), 32'(pc));
    chk({name, ".instr"}, ifid_instr, ins);
  endtask

  // one clock cycle: compare against the model, advance the model, answer memory
  task automatic step();
    logic       exp_req, hs_dut, hs_m, deliver;
    logic [8:0] hs_addr;
    fetch_pkt_t pkt;
    @(negedge clk);
    exp_req = m_run && (exp_q.size() == 0) && !stall && !pc_sel;
    if (m_known) begin
      chk("model.ifid_valid", 32'(ifid_valid), 32'(m_v));
      chk("model.ifid_pc", 32'(ifid_pc), 32'(m_ifpc));
      chk("model.ifid_instr", ifid_instr, m_ifins);
      chk("model.protocol_err", 32'(protocol_err), 32'(m_err));
      chk("model.imem_req", 32'(imem_req), 32'(exp_req));
      if (exp_req) chk("model.imem_addr", 32'(imem_addr), 32'(m_pc));
    end
    hs_dut  = imem_req && imem_gnt;
    hs_addr = imem_addr;
    hs_m    = exp_req && imem_gnt;
    @(posedge clk);
    if (reset) begin
      m_run = 0; m_infl = 0; m_dead = 0; m_err = 0;
      m_pc = '0; m_v = 0; m_ifpc = '0; m_ifins = NOP_INSTR;
      exp_q.delete();
    end else begin
      deliver = 0;
      pkt     = '0;
      if (imem_rvalid && m_run) begin
        if (m_infl) begin
          if (!m_dead) begin
            deliver   = 1;
            pkt.pc    = m_infl_addr;
            pkt.instr = imem_rdata;
          end
          m_infl = 0;
        end else begin
          m_err = 1;
        end
      end
      if (pc_sel) begin
        m_v = 0; m_ifins = NOP_INSTR;
        exp_q.delete();
        m_dead = m_infl;
        m_pc   = {br_pc[8:2], 2'b00};
      end else begin
        if (stall) begin
          if (deliver) exp_q.push_back(pkt);
        end else if (exp_q.size() != 0) begin
          pkt = fetch_pkt_t'(exp_q.pop_front());
          m_v = 1; m_ifpc = pkt.pc; m_ifins = pkt.instr;
        end else if (deliver) begin
          m_v = 1; m_ifpc = pkt.pc; m_ifins = pkt.instr;
        end else begin
          m_v = 0; m_ifins = NOP_INSTR;
        end
        if (hs_m) begin
          m_infl = 1; m_dead = 0; m_infl_addr = m_pc;
          m_pc = m_pc + 9'd4;
        end
      end
      m_run = 1;
    end
    m_known = 1;
    #1;
    imem_rvalid = hs_dut;
    imem_rdata  = 32'(hs_addr);
    cyc++;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1; pc_sel = 0; stall = 0; imem_gnt = 1; imem_rvalid = 0;
    br_pc = '0; imem_rdata = '0;
    step(); step();
    reset = 0;
    chk_ifid("reset", 1'b0, 9'h000, NOP_INSTR);
    chk("reset.protocol_err", 32'(protocol_err), 32'd0);
    chk("reset.imem_req", 32'(imem_req), 32'd0);

    // free run
    step();                                                  // boot edge
    chk("boot.imem_req", 32'(imem_req), 32'd1);
    chk("boot.imem_addr", 32'(imem_addr), 32'h000);
    step();
    chk("run.addr1", 32'(imem_addr), 32'h004);
    chk("run.valid_edge2", 32'(ifid_valid), 32'd0);
    step();
    chk_ifid("run.first", 1'b1, 9'h000, 32'h000);
    chk("run.addr2", 32'(imem_addr), 32'h008);
    step();                                                  // 0x008 accepted

    // stall three cycles right after the 0x008 handshake
    stall = 1;
    step();
    chk_ifid("stall.hold", 1'b1, 9'h004, 32'h004);
    step(); step();
    stall = 0;
    step();
    chk_ifid("stall.release", 1'b1, 9'h008, 32'h008);
    chk("stall.req", 32'(imem_req), 32'd1);
    chk("stall.addr", 32'(imem_addr), 32'h00C);
    step();
    chk("stall.bubble", 32'(ifid_valid), 32'd0);
    step();
    chk_ifid("stall.next", 1'b1, 9'h00C, 32'h00C);

    // redirect while 0x010 is outstanding
    pc_sel = 1; br_pc = 32'h0000_0040;
    step();
    chk_ifid("redir.flush", 1'b0, 9'h00C, NOP_INSTR);
    chk("redir.addr", 32'(imem_addr), 32'h040);
    pc_sel = 0;
    step();
    chk("redir.valid_2nd", 32'(ifid_valid), 32'd0);
    step();
    chk_ifid("redir.target", 1'b1, 9'h040, 32'h040);

    // redirect and stall together, unaligned target
    pc_sel = 1; stall = 1; br_pc = 32'h0000_0043;
    step();
    chk("both.valid", 32'(ifid_valid), 32'd0);
    chk("both.addr", 32'(imem_addr), 32'h040);
    pc_sel = 0;
    step();
    chk("both.req_stalled", 32'(imem_req), 32'd0);
    stall = 0;
    step(); step();
    chk_ifid("both.resume", 1'b1, 9'h040, 32'h040);

    // wrap and grant backpressure
    pc_sel = 1; br_pc = 32'h0000_03F8;
    step();
    chk("wrap.target", 32'(imem_addr), 32'h1F8);
    pc_sel = 0;
    step();
    imem_gnt = 0;
    step();
    chk("gnt.addr1", 32'(imem_addr), 32'h1FC);
    chk("gnt.req1", 32'(imem_req), 32'd1);
    chk_ifid("gnt.ifid", 1'b1, 9'h1F8, 32'h1F8);
    step();
    chk("gnt.addr2", 32'(imem_addr), 32'h1FC);
    chk("gnt.req2", 32'(imem_req), 32'd1);
    imem_gnt = 1;
    step();
    chk("wrap.addr", 32'(imem_addr), 32'h000);
    step();
    chk_ifid("wrap.ifid", 1'b1, 9'h1FC, 32'h1FC);

    // spurious response while idle
    stall = 1;
    step();
    imem_rvalid = 1; imem_rdata = 32'hDEAD_BEEF;
    step();
    chk("err.set", 32'(protocol_err), 32'd1);
    chk_ifid("err.hold", 1'b1, 9'h1FC, 32'h1FC);
    step();
    chk("err.sticky", 32'(protocol_err), 32'd1);
    stall = 0;
    step();
    chk_ifid("err.drain", 1'b1, 9'h000, 32'h000);

    // reset while a read is being accepted
    reset = 1;
    step();
    chk_ifid("rst2", 1'b0, 9'h000, NOP_INSTR);
    chk("rst2.err", 32'(protocol_err), 32'd0);
    chk("rst2.req", 32'(imem_req), 32'd0);
    chk("rst2.addr", 32'(imem_addr), 32'h000);
    reset = 0;
    step();
    chk("rst2.rvalid_ignored", 32'(protocol_err), 32'd0);
    chk("rst2.boot_valid", 32'(ifid_valid), 32'd0);
    step(); step();
    chk_ifid("rst2.first", 1'b1, 9'h000, 32'h000);
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
